// File: rtl/multicycle_control_unit.sv
// Control sequencer for the multicycle CPU: it steps each instruction through IF/ID/EXE/MEM/WB.
// All datapath control lines are combinational decodes of the current state, the opcode and the ALU flags.
module multicycle_control_unit #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            sign,
  output logic [ST_W-1:0] state,
  output logic            PCWre,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic [1:0]      ExtSel,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            RegWre,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            DBDataSrc,
  output logic            mRD,
  output logic            mWR,
  output logic [1:0]      PCSrc
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  typedef enum logic [2:0] {C_ALU, C_BR, C_LS, C_JMP, C_HOLD} class_e;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b010011);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);

  state_e     state_q, state_d;
  class_e     op_cls;
  logic [1:0] dec_ext;
  logic       dec_asa, dec_asb, dec_rtype, br_taken;
  logic [2:0] dec_aluop;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = ST_W'(state_q);

  // Static opcode decode; halt and undefined opcodes fall into C_HOLD.
  always_comb begin
    op_cls    = C_HOLD;
    dec_ext   = 2'b10;
    dec_asa   = 1'b0;
    dec_asb   = 1'b0;
    dec_aluop = 3'b000;
    dec_rtype = 1'b0;
    case (op)
      OP_ADD:   begin op_cls = C_ALU; dec_rtype = 1'b1; end
      OP_SUB:   begin op_cls = C_ALU; dec_rtype = 1'b1; dec_aluop = 3'b001; end
      OP_ADDIU: begin op_cls = C_ALU; dec_asb = 1'b1; end
      OP_AND:   begin op_cls = C_ALU; dec_rtype = 1'b1; dec_aluop = 3'b100; end
      OP_ANDI:  begin op_cls = C_ALU; dec_ext = 2'b01; dec_asb = 1'b1; dec_aluop = 3'b100; end
      OP_ORI:   begin op_cls = C_ALU; dec_ext = 2'b01; dec_asb = 1'b1; dec_aluop = 3'b011; end
      OP_XORI:  begin op_cls = C_ALU; dec_ext = 2'b01; dec_asb = 1'b1; dec_aluop = 3'b110; end
      OP_SLL:   begin op_cls = C_ALU; dec_rtype = 1'b1; dec_ext = 2'b00; dec_asa = 1'b1;
                      dec_aluop = 3'b010; end
      OP_SLTI:  begin op_cls = C_ALU; dec_asb = 1'b1; dec_aluop = 3'b101; end
      OP_SLT:   begin op_cls = C_ALU; dec_rtype = 1'b1; dec_aluop = 3'b101; end
      OP_SW, OP_LW:             begin op_cls = C_LS; dec_asb = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLTZ:  begin op_cls = C_BR; dec_aluop = 3'b001; end
      OP_J, OP_JR, OP_JAL:      op_cls = C_JMP;
      default:                  op_cls = C_HOLD;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = ~zero;
      OP_BLTZ: br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    ExtSel    = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;

    // Operand-path selects stay stable from decode until the instruction retires.
    if (state_q != S_IF) begin
      ExtSel  = dec_ext;
      ALUSrcA = dec_asa;
      ALUSrcB = dec_asb;
    end
    if (state_q != S_IF && state_q != S_ID) ALUOp = dec_aluop;

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (op_cls)
          C_JMP: begin
            PCWre   = 1'b1;
            PCSrc   = (op == OP_JR) ? 2'b10 : 2'b11;
            RegWre  = (op == OP_JAL);
            state_d = S_IF;
          end
          C_BR:    state_d = S_EXE_BR;
          C_LS:    state_d = S_EXE_LS;
          C_ALU:   state_d = S_EXE_AL;
          default: state_d = S_ID;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = dec_rtype ? 2'b10 : 2'b01;
        state_d   = S_IF;
      end
      S_EXE_BR: begin
        PCWre   = 1'b1;
        PCSrc   = br_taken ? 2'b01 : 2'b00;
        state_d = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (op == OP_LW) begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end else begin
          mWR     = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: the full control word is compared every cycle against a queue of
// hand-derived expected words, one per state visited.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0, sign = 1'b0;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] ExtSel, RegDst, PCSrc;
  logic [2:0] ALUOp;

  int checks = 0;
  int failures = 0;
  logic [21:0] exp_q[$];
  logic [21:0] obs, e;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.OP_W(6), .ST_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
  );

  assign obs = {state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

  // Packs one expected control word; InsMemRW is always 1.
  function automatic logic [21:0] pk(input logic [2:0] st, input logic pcwre, input logic irwre,
                                     input logic [1:0] ext, input logic asa, input logic asb,
                                     input logic [2:0] aluop, input logic regwre,
                                     input logic [1:0] regdst, input logic wrsrc, input logic dbsrc,
                                     input logic mrd, input logic mwr, input logic [1:0] pcsrc);
    return {st, pcwre, irwre, 1'b1, ext, asa, asb, aluop, regwre, regdst, wrsrc, dbsrc,
            mrd, mwr, pcsrc};
  endfunction

  localparam logic [21:0] E_IF = {3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000,
                                  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

  task automatic test_reset();
    Reset = 1'b0;
    exp_q.push_back(E_IF);
    exp_q.push_back(E_IF);
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
    Reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    op = 6'b000000;
    exp_q.push_back(E_IF);
    exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd6, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_pre got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
    // Now in WB_AL: reset must take effect without waiting for a clock edge.
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_IF) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, E_IF);
    end
    #2 Reset = 1'b1;
    @(negedge CLK);
    exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd6, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd7, 1, 0, 2'b10, 0, 0, 3'b000, 1, 2'b10, 1, 0, 0, 0, 2'b00));
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_post got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_alu();
    // op, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst
    logic [5:0] t_op[10]  = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                              6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111};
    logic [1:0] t_ext[10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic       t_asa[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       t_asb[10] = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 0};
    logic [2:0] t_alu[10] = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b100,
                              3'b011, 3'b110, 3'b010, 3'b101, 3'b101};
    logic [1:0] t_rd[10]  = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 10; i++) begin
      op   = t_op[i];
      zero = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      exp_q.push_back(E_IF);
      exp_q.push_back(pk(3'd1, 0, 0, t_ext[i], t_asa[i], t_asb[i], 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
      exp_q.push_back(pk(3'd6, 0, 0, t_ext[i], t_asa[i], t_asb[i], t_alu[i], 0, 2'b00, 0, 0, 0, 0, 2'b00));
      exp_q.push_back(pk(3'd7, 1, 0, t_ext[i], t_asa[i], t_asb[i], t_alu[i], 1, t_rd[i], 1, 0, 0, 0, 2'b00));
      while (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL alu op=%b got=%h exp=%h", op, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_load_store();
    op = 6'b110001;
    exp_q.push_back(E_IF);
    exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd2, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd3, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 1, 0, 2'b00));
    exp_q.push_back(pk(3'd4, 1, 0, 2'b10, 0, 1, 3'b000, 1, 2'b01, 1, 1, 0, 0, 2'b00));
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lw got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
    op = 6'b110000;
    exp_q.push_back(E_IF);
    exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd2, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd3, 1, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00));
    exp_q.push_back(E_IF);
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sw got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
    // The trailing IF check above consumed a fetch; finish that instruction (sw again).
    exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd2, 0, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(pk(3'd3, 1, 0, 2'b10, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00));
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sw2 got=%h exp=%h", obs, e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_branch();
    logic [5:0] t_op[6] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101, 6'b110110, 6'b110110};
    logic       t_z[6]  = '{1, 0, 1, 0, 0, 1};
    logic       t_s[6]  = '{0, 1, 1, 0, 1, 0};
    logic [1:0] t_pc[6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      op   = t_op[i];
      zero = t_z[i];
      sign = t_s[i];
      exp_q.push_back(E_IF);
      exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
      exp_q.push_back(pk(3'd5, 1, 0, 2'b10, 0, 0, 3'b001, 0, 2'b00, 0, 0, 0, 0, t_pc[i]));
      while (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL branch op=%b z=%b s=%b got=%h exp=%h", op, zero, sign, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_jump();
    logic [5:0] t_op[3] = '{6'b111000, 6'b111001, 6'b111010};
    logic       t_rw[3] = '{0, 0, 1};
    logic [1:0] t_pc[3] = '{2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      op = t_op[i];
      exp_q.push_back(E_IF);
      exp_q.push_back(pk(3'd1, 1, 0, 2'b10, 0, 0, 3'b000, t_rw[i], 2'b00, 0, 0, 0, 0, t_pc[i]));
      while (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL jump op=%b got=%h exp=%h", op, obs, e);
        end
        @(negedge CLK);
      end
    end
    #1;
    checks++;
    if (obs !== E_IF) begin
      failures++;
      $display("FAIL jump_return got=%h exp=%h", obs, E_IF);
    end
  endtask

  task automatic test_halt();
    logic [5:0] t_op[2] = '{6'b111111, 6'b101010};
    for (int i = 0; i < 2; i++) begin
      op = t_op[i];
      exp_q.push_back(E_IF);
      for (int k = 0; k < 10; k++)
        exp_q.push_back(pk(3'd1, 0, 0, 2'b10, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00));
      while (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL halt op=%b got=%h exp=%h", op, obs, e);
        end
        @(negedge CLK);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (obs !== E_IF) begin
        failures++;
        $display("FAIL halt_reset op=%b got=%h exp=%h", op, obs, E_IF);
      end
      @(negedge CLK);
      Reset = 1'b1;
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_reset_mid();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Finite-state sequencer for the multicycle CPU datapath. It walks each instruction through IF/ID/EXE/MEM/WB phases and drives every datapath control line, including the 2-bit ExtSel of the immediate-extension unit. It sits beside the datapath, taking the opcode from the instruction register plus the ALU zero/sign flags.

Parameters:
OP_W, 6, opcode width
ST_W, 3, state register width (fixed encoding below)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
op  in  OP_W  opcode field of the instruction register
zero  in  1  ALU result == 0
sign  in  1  ALU result MSB
state  out  ST_W  current state (debug / trace)
PCWre  out  1  PC write enable
IRWre  out  1  instruction register write enable
InsMemRW  out  1  instruction memory read (always 1)
ExtSel  out  2  00 sa zero-extend; 01 imm zero-extend; 10 imm sign-extend
ALUSrcA  out  1  0 rs; 1 sa (extended)
ALUSrcB  out  1  0 rt; 1 extended immediate
ALUOp  out  3  000 add; 001 sub; 010 B<<A; 011 or; 100 and; 101 signed A<B; 110 xor
RegWre  out  1  register-file write enable
RegDst  out  2  00 $31; 01 rt; 10 rd
WrRegDSrc  out  1  0 PC+4; 1 write-back data
DBDataSrc  out  1  0 ALU result; 1 data memory
mRD  out  1  data memory read
mWR  out  1  data memory write
PCSrc  out  2  00 PC+4; 01 PC+4+(imm<<2); 10 rs (jr); 11 jump target

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- State register updates on rising CLK. Reset low forces IF immediately, independent of CLK, including mid-instruction. All outputs are combinational decodes of (state, op, zero, sign).
- Reset/IF output values: IRWre=1, InsMemRW=1, PCSrc=00. All other outputs are 0: PCWre, ExtSel=00, ALUSrcA, ALUSrcB, ALUOp=000, RegWre, RegDst=00, WrRegDSrc, DBDataSrc, mRD, mWR, state=000.
- Transitions:
  - IF->ID always.
  - ID: j/jr/jal -> IF; beq/bne/bltz -> EXE_BR; lw/sw -> EXE_LS; halt or undefined opcode -> ID (hold); others -> EXE_AL.
  - EXE_AL->WB_AL->IF.
  - EXE_BR->IF.
  - EXE_LS->MEM.
  - MEM: sw -> IF; lw -> WB_LD -> IF.
- PCWre=1 only in the final state of an instruction: ID for j/jr/jal, EXE_BR, MEM for sw, WB_AL, WB_LD. Never for halt or undefined opcodes.
- jal in ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11. j: PCSrc=11. jr: PCSrc=10.
- ExtSel is held valid from ID through the end of the instruction:
  - sll -> 00
  - andi/ori/xori -> 01
  - all other opcodes -> 10
- ALUSrcA=1 only for sll.
- ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
- ALUOp is valid in EXE_*, MEM, WB_*:
  - add/addiu/lw/sw -> 000
  - sub/beq/bne/bltz -> 001
  - sll -> 010
  - ori -> 011
  - and/andi -> 100
  - slt/slti -> 101
  - xori -> 110
- EXE_BR: PCSrc=01 if taken, else 00.
  - beq taken when zero=1.
  - bne taken when zero=0.
  - bltz taken when sign=1.
- WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type (add, sub, and, sll, slt), 01 for immediate forms.
- MEM: mRD=1 for lw, mWR=1 for sw. mWR is asserted in MEM only.
- WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1.
- IRWre=1 only in IF. No write enable (PCWre, RegWre, mWR) is ever asserted in IF.
- Halt holds in ID with all enables 0 until Reset.

Test Plan:
- Reset low mid-WB_AL, then release -> state=000 during reset, IRWre=1, RegWre=0. Next CLK -> state=001.
- add (000000) -> states 000,001,110,111,000. In WB_AL: RegWre=1, RegDst=10, ALUOp=000, PCWre=1.
- ori (010010) -> ExtSel=01, ALUSrcB=1, ALUOp=011, RegDst=01. sll (011000) -> ExtSel=00, ALUSrcA=1, ALUOp=010.
- lw (110001) -> 000,001,010,011,100,000. mRD=1 in MEM, DBDataSrc=1 in WB_LD. sw (110000) -> mWR=1 in MEM only, then IF, with RegWre=0 throughout.
- beq with zero=1 -> EXE_BR PCSrc=01. bne with zero=1 -> PCSrc=00. bltz with sign=1 -> PCSrc=01. PCWre=1 in each case.
- jal (111010) -> in ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, next IF. halt (111111) and undefined op 101010 -> state stays 001 for 10 cycles with PCWre=RegWre=mWR=0.
